// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with a pending-producer
// scoreboard, optional write-to-read bypass and a sequential post-reset clear engine.
// Register 0 is hardwired to zero and can never be marked pending.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_addr
);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   clr_idx;
    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] pending;
    logic            wr_en;
    logic            iss_en;

    // Writes and issues only take effect once the clear is done, never in a reset
    // cycle, and never to register 0.
    assign wr_en  = ready && !rst && we && (wa != '0);
    assign iss_en = ready && !rst && issue_en && (issue_addr != '0);

    // State register: reset always restarts the clear sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave CLEAR on the cycle the last register is being zeroed.
    always_comb begin
        state_next = state;
        if ((state == CLEAR) && (clr_idx == AW'(NREGS - 1))) begin
            state_next = RUN;
        end
    end

    // Output decode: the port is usable only in RUN.
    always_comb begin
        ready = (state == RUN);
    end

    // Clear index walks every register once per clear sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_idx <= '0;
        end else if (state == CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
        end
    end

    // Register array: zeroed one entry per cycle during CLEAR, written by writeback in RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[clr_idx] <= '0;
            end else if (wr_en) begin
                regs[wa] <= wd;
            end
        end
    end

    // Scoreboard: writeback clears, issue sets; issue is applied last so it wins a tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (wr_en) begin
                pending[wa] <= 1'b0;
            end
            if (iss_en) begin
                pending[issue_addr] <= 1'b1;
            end
        end
    end

    // Combinational read ports with optional same-cycle bypass of the writeback value.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0] addr;
            addr = rd_addr[i*AW +: AW];
            if (ready && (addr != '0)) begin
                rd_data[i*XLEN +: XLEN] = regs[addr];
                rd_busy[i]              = pending[addr];
                if ((BYPASS != 0) && wr_en && (wa == addr)) begin
                    rd_data[i*XLEN +: XLEN] = wd;
                    rd_busy[i]              = iss_en && (issue_addr == addr);
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp. Three instances share one clock
// and reset: default parameters with bypass, default without bypass, and a
// 16-entry, 4-port, 64-bit variant.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;

    // Shared stimulus for the two 32x32 instances
    logic [9:0]  rd_addr;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        issue_en;
    logic [4:0]  issue_addr;

    logic        ready_b, ready_n;
    logic [63:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_busy_b, rd_busy_n;

    // Stimulus for the 16x64, 4-port instance
    logic [15:0]  rd_addr_w;
    logic         we_w;
    logic [3:0]   wa_w;
    logic [63:0]  wd_w;
    logic         ready_w;
    logic [255:0] rd_data_w;
    logic [3:0]   rd_busy_w;

    int checks = 0;
    int errors = 0;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .ready(ready_b),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .we(we), .wa(wa), .wd(wd),
        .issue_en(issue_en), .issue_addr(issue_addr)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .ready(ready_n),
        .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .we(we), .wa(wa), .wd(wd),
        .issue_en(issue_en), .issue_addr(issue_addr)
    );

    regfile_mp #(.XLEN(64), .NREGS(16), .NRD(4), .BYPASS(1)) dut_w (
        .clk(clk), .rst(rst), .ready(ready_w),
        .rd_addr(rd_addr_w), .rd_data(rd_data_w), .rd_busy(rd_busy_w),
        .we(we_w), .wa(wa_w), .wd(wd_w),
        .issue_en(1'b0), .issue_addr(4'd0)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive the writeback/issue inputs of the 32-entry instances.
    task automatic applyStimulus(input logic w, input logic [4:0] a, input logic [31:0] d,
                                 input logic ie, input logic [4:0] ia);
        we         = w;
        wa         = a;
        wd         = d;
        issue_en   = ie;
        issue_addr = ia;
        #1;
    endtask

    // Advance one clock and step just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] wide_val(input int i);
        return {32'h0123_4567, 24'hA5_0000, 8'(i)};
    endfunction

    initial begin
        rst       = 1'b1;
        rd_addr   = '0;
        rd_addr_w = '0;
        we_w      = 1'b0;
        wa_w      = '0;
        wd_w      = '0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

        // 1: reset, then 32 clear cycles (16 for the small instance)
        tick();
        rst = 1'b0;
        rd_addr = {5'd2, 5'd1};
        #1;
        checkOutput("clear_rd_data_zero", rd_data_b, 64'd0);
        for (int c = 1; c <= 32; c++) begin
            checkOutput("clear_ready", {63'd0, ready_b}, 64'd0);
            checkOutput("clear_ready_w", {63'd0, ready_w}, {63'd0, (c > 16)});
            tick();
        end
        checkOutput("ready_cycle33", {63'd0, ready_b}, 64'd1);
        checkOutput("ready_cycle33_nb", {63'd0, ready_n}, 64'd1);
        for (int a = 1; a < 32; a++) begin
            rd_addr = {5'(32 - a), 5'(a)};
            #1;
            checkOutput("post_clear_regs", rd_data_b, 64'd0);
            checkOutput("post_clear_busy", {62'd0, rd_busy_b}, 64'd0);
        end

        // 2: bypass vs. no bypass on a same-cycle write/read of r5
        rd_addr = {5'd0, 5'd5};
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
        checkOutput("bypass_same_cycle", {32'd0, rd_data_b[31:0]}, 64'hDEADBEEF);
        checkOutput("nobypass_same_cycle", {32'd0, rd_data_n[31:0]}, 64'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        checkOutput("nobypass_next_cycle", {32'd0, rd_data_n[31:0]}, 64'hDEADBEEF);
        checkOutput("bypass_next_cycle", {32'd0, rd_data_b[31:0]}, 64'hDEADBEEF);

        // 3: register 0 ignores writes
        rd_addr = {5'd0, 5'd0};
        applyStimulus(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0);
        checkOutput("r0_bypass_data", rd_data_b, 64'd0);
        checkOutput("r0_bypass_busy", {62'd0, rd_busy_b}, 64'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        checkOutput("r0_data", rd_data_b, 64'd0);
        checkOutput("r0_data_nb", rd_data_n, 64'd0);
        checkOutput("r0_busy", {62'd0, rd_busy_b}, 64'd0);

        // 4: scoreboard on r7, both ports aliased
        rd_addr = {5'd7, 5'd7};
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        checkOutput("issue_same_cycle_busy", {62'd0, rd_busy_b}, 64'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        checkOutput("issue_busy", {62'd0, rd_busy_b}, 64'd3);
        checkOutput("issue_busy_nb", {62'd0, rd_busy_n}, 64'd3);
        applyStimulus(1'b1, 5'd7, 32'd77, 1'b0, 5'd0);
        checkOutput("wb_bypass_busy", {62'd0, rd_busy_b}, 64'd0);
        checkOutput("wb_nobypass_busy", {62'd0, rd_busy_n}, 64'd3);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        checkOutput("wb_busy_after", {62'd0, rd_busy_b}, 64'd0);
        checkOutput("wb_busy_after_nb", {62'd0, rd_busy_n}, 64'd0);
        checkOutput("wb_data_after", rd_data_b, {32'd77, 32'd77});
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        tick();
        applyStimulus(1'b1, 5'd7, 32'd88, 1'b1, 5'd7);
        checkOutput("issue_wb_same_busy", {62'd0, rd_busy_b}, 64'd3);
        checkOutput("issue_wb_same_data", rd_data_b, {32'd88, 32'd88});
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        checkOutput("issue_wb_busy_after", {62'd0, rd_busy_b}, 64'd3);
        checkOutput("issue_wb_busy_after_nb", {62'd0, rd_busy_n}, 64'd3);
        checkOutput("issue_wb_data_after", rd_data_n, {32'd88, 32'd88});

        // 5: reset in the middle of RUN
        rd_addr = {5'd4, 5'd3};
        applyStimulus(1'b1, 5'd3, 32'hA5, 1'b1, 5'd4);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        checkOutput("pre_rst_r3", {32'd0, rd_data_b[31:0]}, 64'hA5);
        checkOutput("pre_rst_r4_busy", {63'd0, rd_busy_b[1]}, 64'd1);
        rst = 1'b1;
        applyStimulus(1'b1, 5'd3, 32'hFF, 1'b0, 5'd0);
        checkOutput("rst_cycle_no_bypass", {32'd0, rd_data_b[31:0]}, 64'hA5);
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 5'd3, 32'h55, 1'b1, 5'd4);
        checkOutput("rst_ready_drop", {63'd0, ready_b}, 64'd0);
        checkOutput("rst_clear_read", rd_data_b, 64'd0);
        for (int c = 0; c < 32; c++) begin
            tick();
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        checkOutput("rst_ready_back", {63'd0, ready_b}, 64'd1);
        checkOutput("rst_r3_cleared", {32'd0, rd_data_b[31:0]}, 64'd0);
        checkOutput("rst_r3_cleared_nb", {32'd0, rd_data_n[31:0]}, 64'd0);
        checkOutput("rst_r4_not_busy", {62'd0, rd_busy_b}, 64'd0);

        // 6: 16 x 64-bit, four ports
        checkOutput("wide_ready", {63'd0, ready_w}, 64'd1);
        for (int i = 1; i < 16; i++) begin
            we_w = 1'b1;
            wa_w = 4'(i);
            wd_w = wide_val(i);
            tick();
        end
        we_w = 1'b0;
        rd_addr_w = {4'd7, 4'd7, 4'd15, 4'd1};
        #1;
        checkOutput("wide_p0", rd_data_w[63:0],    64'h0123_4567_A500_0001);
        checkOutput("wide_p1", rd_data_w[127:64],  64'h0123_4567_A500_000F);
        checkOutput("wide_p2", rd_data_w[191:128], 64'h0123_4567_A500_0007);
        checkOutput("wide_p3", rd_data_w[255:192], 64'h0123_4567_A500_0007);
        rd_addr_w = {4'd2, 4'd15, 4'd15, 4'd0};
        #1;
        checkOutput("wide_r0", rd_data_w[63:0],    64'd0);
        checkOutput("wide_alias1", rd_data_w[127:64],  64'h0123_4567_A500_000F);
        checkOutput("wide_alias2", rd_data_w[191:128], 64'h0123_4567_A500_000F);
        checkOutput("wide_p3_r2", rd_data_w[255:192], 64'h0123_4567_A500_0002);
        we_w = 1'b1;
        wa_w = 4'd2;
        wd_w = 64'hFEDC_BA98_7654_3210;
        #1;
        checkOutput("wide_bypass", rd_data_w[255:192], 64'hFEDC_BA98_7654_3210);
        checkOutput("wide_bypass_other", rd_data_w[127:64], 64'h0123_4567_A500_000F);
        checkOutput("wide_busy", {60'd0, rd_busy_w}, 64'd0);
        tick();
        we_w = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL timeout got=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
